// File: rtl/mem_stage.sv
// ============================================================================
// Module   : mem_stage
// Purpose  : Pipeline MEM stage. Accepts one EX result at a time, passes ALU
//            results straight to writeback, and turns loads/stores into a
//            single registered data-memory request. It waits for dmem_ack,
//            then hands the extracted load data (or a store completion) to WB.
// Ports    : clk, rst (async, active-low)
//            EX side  : in_valid, in_ready, alu_result, store_data, mem_read,
//                       mem_write, funct3, rd, reg_write
//            DMEM side: dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
//                       dmem_ack, dmem_rdata
//            WB side  : wb_valid, wb_rd, wb_data, wb_reg_write, misalign
// Options  : MEM_STAGE_MISALIGN_TRAP_EN - misaligned half/word accesses are
//            not sent to memory; they complete at once with misalign = 1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage #(
  parameter int WIDTH = 32  // byte lanes are fixed at 4, so only 32 works
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] store_data,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [2:0]       funct3,
  input  logic [4:0]       rd,
  input  logic             reg_write,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  output logic [3:0]       dmem_be,
  input  logic             dmem_ack,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             wb_reg_write,
  output logic             misalign
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;

  logic             accept;
  logic             is_mem;
  logic             trap;
  logic [3:0]       st_be;
  logic [WIDTH-1:0] st_wdata;
  logic [WIDTH-1:0] load_data;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;

  // Fields of the in-flight memory op, needed when the ack arrives.
  logic [1:0]       lat_off;
  logic [2:0]       lat_funct3;
  logic [4:0]       lat_rd;
  logic             lat_rw;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign is_mem   = mem_read || mem_write;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  // funct3[1:0] encodes the size: 01 = half, 10 = word.
  assign trap = is_mem &&
                (((funct3[1:0] == 2'b01) && alu_result[0]) ||
                 ((funct3[1:0] == 2'b10) && (alu_result[1:0] != 2'b00)));
`else
  assign trap     = 1'b0;
  assign misalign = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && is_mem && !trap) state_next = WAIT;
      WAIT:    if (dmem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Store lane steering: data is replicated so the enabled lanes always see it.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = store_data;
    case (funct3)
      3'b000: begin
        st_be    = 4'b0001 << alu_result[1:0];
        st_wdata = {4{store_data[7:0]}};
      end
      3'b001: begin
        st_be    = alu_result[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction from the returned word using the latched offset.
  always_comb begin
    byte_sel  = dmem_rdata[8*lat_off +: 8];
    half_sel  = lat_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_data = dmem_rdata;
    case (lat_funct3)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = dmem_rdata;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_be      <= 4'b0000;
      wb_valid     <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= '0;
      wb_reg_write <= 1'b0;
      lat_off      <= 2'b00;
      lat_funct3   <= 3'b000;
      lat_rd       <= 5'd0;
      lat_rw       <= 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      misalign     <= 1'b0;
`endif
    end else begin
      wb_valid <= 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      misalign <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mem && !trap) begin
              dmem_req   <= 1'b1;
              dmem_we    <= mem_write;  // store wins when both are set
              dmem_addr  <= {alu_result[WIDTH-1:2], 2'b00};
              dmem_wdata <= st_wdata;
              dmem_be    <= st_be;
              lat_off    <= alu_result[1:0];
              lat_funct3 <= funct3;
              lat_rd     <= rd;
              lat_rw     <= reg_write && !mem_write;
            end else begin
              wb_valid     <= 1'b1;
              wb_data      <= alu_result;
              wb_rd        <= rd;
              wb_reg_write <= reg_write && !trap;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
              misalign     <= trap;
`endif
            end
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            wb_valid     <= 1'b1;
            wb_data      <= load_data;
            wb_rd        <= lat_rd;
            wb_reg_write <= lat_rw;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, datapath width; only 32 is supported because byte lanes are fixed at 4.
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port in_valid  input  1  EX result valid this cycle.
REQ-005 The block SHALL have port in_ready  output  1  block can accept an EX result.
REQ-006 The block SHALL have port alu_result  input  WIDTH  ALU output; byte address for loads and stores.
REQ-007 The block SHALL have port store_data  input  WIDTH  rs2 value passed through EX.
REQ-008 The block SHALL have ports mem_read and mem_write  input  1 each  load or store request.
REQ-009 The block SHALL have ports funct3  input  3  access size and sign; rd  input  5  destination register; reg_write  input  1  writeback enable.
REQ-010 The block SHALL have ports dmem_req  output  1, dmem_we  output  1, dmem_addr  output  WIDTH, dmem_wdata  output  WIDTH, dmem_be  output  4; all registered.
REQ-011 The block SHALL have ports dmem_ack  input  1  and dmem_rdata  input  WIDTH; rdata is valid in the ack cycle.
REQ-012 The block SHALL have ports wb_valid  output  1, wb_rd  output  5, wb_data  output  WIDTH, wb_reg_write  output  1, misalign  output  1.

Function
REQ-013 FSM states SHALL be IDLE and WAIT; in_ready SHALL be 1 exactly in IDLE.
REQ-014 An EX result SHALL be accepted when in_valid and in_ready are both 1.
REQ-015 A non-memory op SHALL stay in IDLE and produce a one-cycle wb_valid on the next cycle, with wb_data = alu_result, wb_rd = rd and wb_reg_write = reg_write; back-to-back acceptance SHALL be sustained.
REQ-016 A memory op SHALL move the FSM to WAIT and assert dmem_req on the next cycle.
REQ-017 For a memory op, dmem_addr SHALL be {alu_result[WIDTH-1:2],2'b00}, and the byte offset SHALL be latched internally.
REQ-018 mem_write SHALL take priority over mem_read when both are set; dmem_we SHALL be 1 for stores.
REQ-019 Store lanes:
- SB (000): dmem_be = 1<<off; the low byte SHALL be replicated to all 4 lanes.
- SH (001): dmem_be = off[1] ? 1100 : 0011; the low half SHALL be replicated to both halves.
- SW (010) and all other codes: dmem_be = 1111.
REQ-020 dmem_req, dmem_addr, dmem_wdata, dmem_be and dmem_we SHALL stay stable until dmem_ack is sampled high.
REQ-021 On the ack edge, dmem_req SHALL deassert, the FSM SHALL return to IDLE, and wb_valid SHALL pulse on the following cycle; total latency is 2 + memory wait cycles.
REQ-022 Load extraction:
- LB (000) / LBU (100): select the byte at off, then sign-extend / zero-extend.
- LH (001) / LHU (101): select the half at off[1], then sign-extend / zero-extend.
- LW (010) and other codes: pass the full word.
REQ-023 A store SHALL force wb_reg_write = 0; a load SHALL use the latched reg_write and rd.
REQ-024 A dmem_ack while in IDLE SHALL be ignored.
REQ-025 wb_valid SHALL be a single-cycle pulse; the WB stage has no backpressure.

Reset
REQ-026 When rst is low, the following SHALL be reset immediately:
- the FSM to IDLE;
- dmem_req, dmem_we, wb_valid, wb_reg_write and misalign to 0;
- dmem_addr, dmem_wdata, wb_data and wb_rd to 0, and dmem_be to 0000.
REQ-027 A reset mid-transaction SHALL abandon the access without issuing wb_valid; in_ready SHALL be 1 on the first cycle after rst deasserts.

Configuration
REQ-028 With macro MEM_STAGE_MISALIGN_TRAP_EN defined, the following accesses SHALL NOT issue dmem_req:
- a halfword access with off[0] = 1;
- a word access with off != 00.
Instead, the FSM SHALL stay in IDLE and the next cycle SHALL carry wb_valid = 1, misalign = 1 and wb_reg_write = 0.
REQ-029 Without the macro, misalign SHALL be tied to 0 and misaligned accesses SHALL use the lane selection in REQ-019 and REQ-022 unchanged.

Verification
REQ-030 ALU op: alu_result = 0x0000_0042, rd = 5, reg_write = 1 -> next cycle wb_valid = 1, wb_data = 0x42, wb_rd = 5, in_ready stays 1.
REQ-031 LB: addr = 0x103, dmem_rdata = 0x80FF_FFFF, ack after 2 wait cycles -> dmem_addr = 0x100, wb_data = 0xFFFF_FF80; with LBU -> 0x0000_0080.
REQ-032 SH: addr = 0x202, store_data = 0x1234_ABCD -> dmem_be = 1100, dmem_wdata = 0xABCD_ABCD, dmem_we = 1, wb_reg_write = 0.
REQ-033 Reset during WAIT: rst low while dmem_req = 1 -> dmem_req = 0 immediately, no wb_valid, in_ready = 1 after release.
REQ-034 With the macro defined, LW at 0x101 -> no dmem_req, next cycle misalign = 1 and wb_valid = 1; without the macro, dmem_req is issued at 0x100 and misalign stays 0.
